// File: rtl/countdown_ctrl_16bit_pkg.sv
// Shared types and constants for the countdown sequencer (countdown_ctrl_16bit).
package countdown_ctrl_16bit_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOADED = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/countdown_ctrl_16bit_decrement.sv
// 16-bit decrement datapath: dec_o = a_i - 1, ovf_o flags the wrap from zero.
module decrement_16bit
  import countdown_ctrl_16bit_pkg::*;
(
  input  logic [CNT_W-1:0] a_i,
  output logic [CNT_W-1:0] dec_o,
  output logic             ovf_o
);

  assign dec_o = a_i - CNT_W'(1);
  assign ovf_o = (a_i == '0);

endmodule

// File: rtl/countdown_ctrl_16bit_tick_prescaler.sv
// PRESCALE-modulo tick counter; step_o strobes on the last phase while enabled.
module tick_prescaler
  import countdown_ctrl_16bit_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic step_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign step_o = en_i && (cnt_q == LAST);

  // With en_i low the phase simply holds, which is what makes pause lossless.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_ctrl_16bit.sv
// Loadable 16-bit countdown sequencer with prescaled steps and a one-cycle done pulse.
// Optional `COUNTDOWN_AUTO_RELOAD_EN: reload the count on reaching zero and keep running.
module countdown_ctrl_16bit
  import countdown_ctrl_16bit_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [CNT_W-1:0] reload_q;
`endif

  logic [CNT_W-1:0] decVal;
  logic             decOvf;
  logic             runEn;
  logic             prescClr;
  logic             step;

  // Prescaler advances only on edges where the run is active and pause is low.
  assign runEn    = ((state_q == ST_RUN) || (state_q == ST_PAUSED)) && !pause && !abort;
  assign prescClr = abort || ((state_q == ST_LOADED) && start);

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) uPrescaler (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (runEn),
    .clr_i (prescClr),
    .step_o(step)
  );

  decrement_16bit uDecrement (
    .a_i  (count_q),
    .dec_o(decVal),
    .ovf_o(decOvf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
        count_q <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (load) begin
              state_q  <= ST_LOADED;
              count_q  <= load_val;
              busy_q   <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              reload_q <= load_val;
`endif
            end
          end
          ST_LOADED: begin
            if (start) begin
              if (count_q == '0) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q <= ST_RUN;
              end
            end
          end
          ST_RUN, ST_PAUSED: begin
            state_q <= pause ? ST_PAUSED : ST_RUN;
            // A step from zero would wrap; flag it and keep the count at zero.
            if (step) begin
              if (decOvf) begin
                err_q   <= 1'b1;
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
              end else if (decVal == '0) begin
                done_q <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (reload_q != '0) begin
                  count_q <= reload_q;
                end else begin
                  count_q <= '0;
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                end
`else
                count_q <= '0;
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
`endif
              end else begin
                count_q <= decVal;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule
